// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the RV32I load/store unit.
package lsu_pkg;

   localparam int FUNCT3_W = 3;

   localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
   localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
   localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
   localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
   localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      EXC_NONE     = 2'b00,
      EXC_MISALIGN = 2'b01,
      EXC_TIMEOUT  = 2'b10,
      EXC_ILLEGAL  = 2'b11
   } lsu_exc_t;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT_ACK = 2'b01,
      RESP     = 2'b10
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store replication, load extraction
// with sign/zero extension, and request legality checks.
module lsu_align
   import lsu_pkg::*;
(
   input  logic                is_store,
   input  logic [FUNCT3_W-1:0] funct3,
   input  logic [1:0]          addr_lo,
   input  logic [31:0]         wdata,
   input  logic [31:0]         rdata,
   output logic [3:0]          be,
   output logic [31:0]         wdata_lane,
   output logic [31:0]         rdata_ext,
   output logic                misaligned,
   output logic                illegal
);

   logic [31:0]        shifted;
   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   always_comb begin
      illegal    = is_store ? (funct3 > F3_W)
                            : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
      misaligned = (funct3[1:0] == 2'b01 && addr_lo[0]) ||
                   (funct3[1:0] == 2'b10 && addr_lo != 2'b00);

      be         = 4'b1111;
      wdata_lane = wdata;
      case (funct3[1:0])
         2'b00: begin
            be         = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
         end
         2'b01: begin
            be         = 4'b0011 << addr_lo;
            wdata_lane = {2{wdata[15:0]}};
         end
         default: be = 4'b1111;
      endcase
      // Loads always fetch the whole word; extraction happens on the way back.
      if (!is_store) be = 4'b0000;

      shifted   = rdata >> {addr_lo, 3'b000};
      byte_s    = shifted[7:0];
      half_s    = shifted[15:0];
      rdata_ext = shifted;
      case (funct3)
         F3_B:    rdata_ext = 32'(byte_s);
         F3_H:    rdata_ext = 32'(half_s);
         F3_BU:   rdata_ext = {24'd0, shifted[7:0]};
         F3_HU:   rdata_ext = {16'd0, shifted[15:0]};
         default: rdata_ext = shifted;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request/ack transaction on the data-memory port per
// execute-stage op, with timeout abort and a one-cycle writeback response.
module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_is_store,
   input  logic [FUNCT3_W-1:0] req_funct3,
   input  logic [31:0]         req_addr,
   input  logic [31:0]         req_wdata,
   input  logic [4:0]          req_rd,
   output logic                mem_req,
   output logic                mem_we,
   output logic [31:0]         mem_addr,
   output logic [31:0]         mem_wdata,
   output logic [3:0]          mem_be,
   input  logic                mem_ack,
   input  logic [31:0]         mem_rdata,
   output logic                rsp_valid,
   output logic [31:0]         rsp_data,
   output logic [4:0]          rsp_rd,
   output logic [1:0]          rsp_exc
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   lsu_state_t          state, state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic                is_store_q;
   logic [FUNCT3_W-1:0] funct3_q;
   logic [1:0]          addr_lo_q;
   logic [4:0]          rd_q;

   logic                al_store;
   logic [FUNCT3_W-1:0] al_funct3;
   logic [1:0]          al_addr_lo;
   logic [3:0]          al_be;
   logic [31:0]         al_wdata;
   logic [31:0]         al_rdata;
   logic                al_misaligned;
   logic                al_illegal;
   logic                timeout_hit;

   // The aligner decodes the live request in IDLE and the captured one afterwards.
   assign al_store   = (state == IDLE) ? req_is_store       : is_store_q;
   assign al_funct3  = (state == IDLE) ? req_funct3         : funct3_q;
   assign al_addr_lo = (state == IDLE) ? req_addr[1:0]      : addr_lo_q;

   lsu_align u_align (
      .is_store   (al_store),
      .funct3     (al_funct3),
      .addr_lo    (al_addr_lo),
      .wdata      (req_wdata),
      .rdata      (mem_rdata),
      .be         (al_be),
      .wdata_lane (al_wdata),
      .rdata_ext  (al_rdata),
      .misaligned (al_misaligned),
      .illegal    (al_illegal)
   );

   assign req_ready   = (state == IDLE);
   assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid)
               state_nxt = (al_illegal || al_misaligned) ? RESP : WAIT_ACK;
         end
         WAIT_ACK: begin
            if (mem_ack || timeout_hit) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_rd     <= '0;
         rsp_exc    <= EXC_NONE;
         cnt        <= '0;
         is_store_q <= 1'b0;
         funct3_q   <= '0;
         addr_lo_q  <= '0;
         rd_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  is_store_q <= req_is_store;
                  funct3_q   <= req_funct3;
                  addr_lo_q  <= req_addr[1:0];
                  rd_q       <= req_rd;
                  cnt        <= '0;
                  // Illegal outranks misaligned; neither touches memory.
                  if (al_illegal || al_misaligned) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= '0;
                     rsp_rd    <= '0;
                     rsp_exc   <= al_illegal ? EXC_ILLEGAL : EXC_MISALIGN;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= req_is_store;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= al_wdata;
                     mem_be    <= al_be;
                  end
               end
            end
            WAIT_ACK: begin
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_data  <= is_store_q ? 32'd0 : al_rdata;
                  rsp_rd    <= is_store_q ? 5'd0 : rd_q;
                  rsp_exc   <= EXC_NONE;
               end else if (timeout_hit) begin
                  mem_req   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
                  rsp_rd    <= '0;
                  rsp_exc   <= EXC_TIMEOUT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: rsp_valid <= 1'b0;
            default: rsp_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed cases plus randomized ops against a
// byte-arithmetic reference model; responses checked by a separate monitor.
module tb_lsu;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_store = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;
   logic [1:0]  rsp_exc;

   lsu #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_exc(rsp_exc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic [1:0]  exc;
      int          at;
   } rsp_t;

   rsp_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: sizes, offsets and masks straight from the ISA rules.
   task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int ack,
                        output logic [1:0] exc, output logic [31:0] ldata,
                        output logic [3:0] be, output logic [31:0] wd, output int lat);
      int          size;
      int          off;
      bit          ill;
      bit          mis;
      logic [31:0] v;
      logic [31:0] mask;
      size = 1 << f3[1:0];
      off  = int'(addr % 4);
      ill  = st ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7);
      mis  = (addr % size) != 0;
      be   = st ? 4'(((1 << size) - 1) << off) : 4'd0;
      wd   = (size == 1) ? wdata[7:0] * 32'h01010101 :
             (size == 2) ? wdata[15:0] * 32'h00010001 : wdata;
      v    = rdata >> (8 * off);
      mask = (size >= 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 32'd1);
      v    = v & mask;
      if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
      ldata = 32'd0;
      if (ill) begin
         exc = 2'b11; lat = 1;
      end else if (mis) begin
         exc = 2'b01; lat = 1;
      end else if (ack >= 1 && ack <= T) begin
         exc = 2'b00; lat = ack + 1; ldata = st ? 32'd0 : v;
      end else begin
         exc = 2'b10; lat = T + 1;
      end
   endtask

   task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [4:0] rd,
                     input logic [31:0] rdata, input int ack);
      logic [1:0]  exc;
      logic [31:0] ldata;
      logic [3:0]  be;
      logic [31:0] wd;
      int          lat;
      bit          mem_path;
      rsp_t        e;
      model(st, f3, addr, wdata, rdata, ack, exc, ldata, be, wd, lat);
      mem_path = (exc == 2'b00 || exc == 2'b10);
      @(negedge clk);
      mem_ack      = 1'b0;
      req_valid    = 1'b1;
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = addr;
      req_wdata    = wdata;
      req_rd       = rd;
      chk("req_ready_idle", req_ready, 1);
      e.data = ldata;
      e.rd   = (!st && exc == 2'b00) ? rd : 5'd0;
      e.exc  = exc;
      e.at   = cyc + lat;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         chk("mem_req", mem_req, mem_path && c < lat);
         if (mem_path && c < lat) begin
            chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
            chk("mem_we", mem_we, st);
            chk("mem_be", mem_be, be);
            if (st) chk("mem_wdata", mem_wdata, wd);
         end
         if (mem_path && c == ack && c < lat) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
         end
         if (c == lat) begin
            chk("req_ready_busy", req_ready, 0);
            // Spurious ack and an unaccepted request while busy must be ignored.
            mem_ack      = 1'($urandom_range(0, 1));
            req_valid    = 1'($urandom_range(0, 1));
            req_is_store = 1'($urandom_range(0, 1));
         end
      end
   endtask

   always @(negedge clk) begin
      rsp_t e;
      if (rst_n && rsp_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got data=%h rd=%0d exc=%0d want none", rsp_data, rsp_rd, rsp_exc);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_rd", 32'(rsp_rd), 32'(e.rd));
            chk("rsp_exc", 32'(rsp_exc), 32'(e.exc));
            chk("rsp_cycle", cyc, e.at);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] w;
      logic [31:0] r;
      #12;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_exc", 32'(rsp_exc), 0);
      @(negedge clk);
      rst_n = 1'b1;

      op(1'b1, 3'b000, 32'h0000_1003, 32'hDEAD_BEEF, 5'd7, 32'h0, 1);
      op(1'b0, 3'b000, 32'h0000_2002, 32'h0, 5'd5, 32'h1280_7F34, 1);
      op(1'b0, 3'b100, 32'h0000_2002, 32'h0, 5'd5, 32'h1280_7F34, 2);
      op(1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd9, 32'hBEEF_1234, 1);
      op(1'b0, 3'b010, 32'h0000_2006, 32'h0, 5'd3, 32'h0, 1);
      op(1'b1, 3'b100, 32'h0000_1000, 32'h1234_5678, 5'd4, 32'h0, 1);
      op(1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd1, 32'hCAFE_F00D, 0);
      op(1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd2, 32'hCAFE_F00D, 4);
      op(1'b1, 3'b001, 32'h0000_1002, 32'h0000_CAFE, 5'd0, 32'h0, 3);
      op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 5'd31, 32'h8001_0000, 1);

      // Reset pulse while waiting for an ack.
      @(negedge clk);
      mem_ack      = 1'b0;
      req_valid    = 1'b1;
      req_is_store = 1'b0;
      req_funct3   = 3'b010;
      req_addr     = 32'h0000_3000;
      req_rd       = 5'd6;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rstmid_mem_req_before", mem_req, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_mem_req", mem_req, 0);
      chk("rstmid_rsp_valid", rsp_valid, 0);
      chk("rstmid_req_ready", req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rstmid_no_rsp", rsp_valid, 0);
         chk("rstmid_idle", req_ready, 1);
      end
      op(1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd6, 32'h0BAD_F00D, 2);

      for (int i = 0; i < 300; i++) begin
         a = $urandom;
         w = $urandom;
         r = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, w,
            5'($urandom_range(0, 31)), r, $urandom_range(0, 6));
      end

      @(negedge clk);
      req_valid = 1'b0;
      mem_ack   = 1'b0;
      repeat (8) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I execute path, directly downstream of the integer ALU. It consumes the ALU's `ADD` result as the effective address, plus rs2 store data and the instruction's funct3. It runs one request/acknowledge transaction on the word-wide data-memory port, with byte-enable generation and load sign/zero extension. It returns a one-cycle writeback response carrying data, destination register and an exception code.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles `mem_req` may stay high without `mem_ack` before abort; 0 disables the timeout.
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  execute stage presents a memory op
- `req_ready`  out  1  high only in IDLE
- `req_is_store`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr`  in  32  effective address (ALU output)
- `req_wdata`  in  32  rs2 value
- `req_rd`  in  5  load destination
- `mem_req`  out  1  transaction request, held until ack/abort
- `mem_we`  out  1  write strobe
- `mem_addr`  out  32  `{req_addr[31:2],2'b00}`
- `mem_wdata`  out  32  lane-replicated store data
- `mem_be`  out  4  byte enables
- `mem_ack`  in  1  memory completion
- `mem_rdata`  in  32  read word, valid with `mem_ack`
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_data`  out  32  extended load data; 0 for stores/exceptions
- `rsp_rd`  out  5  `req_rd` for successful loads, else 0
- `rsp_exc`  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal funct3

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, capture all request fields, then:
    - illegal/misaligned request → RESP with the matching exc; no memory access.
    - otherwise → WAIT_ACK.
  - WAIT_ACK: `mem_req`=1, all `mem_*` stable. On `mem_ack` → capture rdata → RESP. On timeout → drop `mem_req` → RESP with exc 10.
  - RESP: `rsp_valid`=1 for one cycle → IDLE.
- Illegal funct3: loads 011/110/111; stores anything except 000/001/010. Illegal takes priority over misaligned.
- Misaligned: H/HU with `addr[0]`=1; W with `addr[1:0]`≠0.
- Byte enables:
  - B: `4'b0001<<addr[1:0]`
  - H: `4'b0011<<addr[1:0]`
  - W: `4'b1111`
  - `mem_be`=0 for loads (the full word is read).
- Store data: B `{4{wdata[7:0]}}`, H `{2{wdata[15:0]}}`, W unchanged.
- Load extract: `mem_rdata >> (8*addr[1:0])`, then:
  - B/H sign-extend.
  - BU/HU zero-extend.
  - W unchanged.
- Timeout counter: cleared on entering WAIT_ACK; increments each WAIT_ACK cycle without ack.

## Timing
- Cycle 0: handshake (`req_valid & req_ready`).
- Cycle 1: `mem_req` first high. Ack sampled in cycle k≥1 gives `rsp_valid` in cycle k+1. Minimum latency: ack in cycle 1 → response in cycle 2.
- Exception paths (illegal/misaligned): `rsp_valid` in cycle 1; `mem_req` never asserts.
- Timeout: abort once `TIMEOUT_CYCLES` consecutive WAIT_ACK cycles pass without ack. `mem_req` is low and `rsp_valid` high in the following cycle.
- Ack in the same cycle as timeout expiry: ack wins, exc 00.
- `mem_ack` outside WAIT_ACK is ignored.
- `req_valid` while `req_ready`=0 is not consumed; the upstream stage holds it.
- All outputs are registered except `req_ready` (decoded from state).
- Reset values:
  - state IDLE, so `req_ready`=1.
  - `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` = 0.
  - `rsp_valid`, `rsp_data`, `rsp_rd`, `rsp_exc` = 0.
  - counter = 0.
- Reset mid-transaction: `mem_req` drops asynchronously; no response is issued.

## Structure
- `lsu_pkg` holds:
  - funct3 width constants;
  - `lsu_exc_t` enum (NONE, MISALIGN, TIMEOUT, ILLEGAL);
  - `lsu_state_t` enum (IDLE, WAIT_ACK, RESP).
- One combinational sub-module, `lsu_align`:
  - inputs: funct3, `addr[1:0]`, wdata, rdata;
  - outputs: be, steered wdata, extended load data, misaligned/illegal flags.
- The `lsu` top level holds the FSM, timeout counter and registers.

## Test plan
- SB addr 0x1003, wdata 0xDEADBEEF, ack in cycle 1 → `mem_addr` 0x1000, `mem_be` 0b1000, `mem_wdata` 0xEFEFEFEF, `mem_we`=1; `rsp_valid` in cycle 2 with `rsp_rd`=0, exc 00.
- LB addr 0x2002, rd=5, rdata 0x12807F34 → `rsp_data` 0xFFFFFF80, `rsp_rd`=5. Repeat as LBU → 0x00000080.
- LH addr 0x2002, rdata 0xBEEF1234 → `rsp_data` 0xFFFFBEEF. LW addr 0x2006 → exc 01 in cycle 1, `mem_req` never high.
- Store with funct3 100 → exc 11 in cycle 1, no memory access.
- `TIMEOUT_CYCLES`=4, ack withheld → `mem_req` high cycles 1–4, low cycle 5 with `rsp_valid`, exc 10. Ack exactly in cycle 4 → exc 00.
- `rst_n` pulsed low during WAIT_ACK → `mem_req` low immediately, no `rsp_valid`, `req_ready`=1 after release; a following LW completes normally.
